// File: rtl/qsfp_diag_scan.sv
// qsfp_diag_scan
// Periodically walks every QSFP's lower-page diagnostic bytes through the
// qsfpMarble byte-read port and checks the identifier for presence. It builds
// big-endian 16-bit words (temperature, Vcc, RX power ch1..4) in a staging
// array. In the DONE cycle it publishes the staging array, with the presence
// and alarm bitmaps, as one coherent snapshot.
// Optional build macro: QSFP_DIAG_ALARM_EN adds the signed over-temperature
// comparator. When it is undefined, tempAlarm is tied to 0.
module qsfp_diag_scan #(
    parameter int                 QSFP_COUNT           = 2,
    parameter int                 SCAN_INTERVAL        = 100000,
    parameter int                 READ_LATENCY         = 1,
    parameter logic signed [15:0] TEMP_ALARM_THRESHOLD = 16'sd17920
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [$clog2(QSFP_COUNT)+7:0] readAddress,
    input  logic [7:0]                    readData,
    input  logic [$clog2(QSFP_COUNT)+2:0] diagAddress,
    output logic [15:0]                   diagData,
    output logic [QSFP_COUNT-1:0]         present,
    output logic [QSFP_COUNT-1:0]         tempAlarm,
    output logic                          scanBusy,
    output logic                          scanDone,
    output logic [15:0]                   scanCount
);

    localparam int MW = $clog2(QSFP_COUNT);
    localparam int IW = (MW > 0) ? MW : 1;
    localparam int AW = MW + 8;
    localparam int CW = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;
    localparam int WW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   interval_reg;
    logic [WW-1:0]   wait_reg;
    logic [IW-1:0]   mod_reg;
    logic [3:0]      idx_reg;
    logic [7:0]      hi_reg;
    logic [AW-1:0]   readAddress_reg;
    logic [15:0]     diagData_reg;
    logic [15:0]     scanCount_reg;

    logic [15:0]           stage_word_reg [QSFP_COUNT][6];
    logic [QSFP_COUNT-1:0] stage_present_reg;
    logic [15:0]           pub_word_reg   [QSFP_COUNT][6];
    logic [QSFP_COUNT-1:0] pub_present_reg;

    logic          id_valid;
    logic          last_mod;
    logic          is_capture;
    logic          module_end;
    logic          lo_capture;
    logic [2:0]    word_sel;
    logic [IW-1:0] diag_mod;
    logic [2:0]    diag_word;

    // Byte offset within the lower page for each step of a module's read list.
    // Steps 5..12 cover the contiguous RX power bytes 34..41.
    function automatic logic [7:0] byte_offset(input logic [3:0] idx);
        logic [7:0] off;
        case (idx)
            4'd0:    off = 8'd0;
            4'd1:    off = 8'd22;
            4'd2:    off = 8'd23;
            4'd3:    off = 8'd26;
            4'd4:    off = 8'd27;
            default: off = 8'd29 + {4'd0, idx};
        endcase
        return off;
    endfunction

    // Decode of the byte currently being captured
    always_comb begin
        id_valid   = (readData == 8'h0C) || (readData == 8'h0D) || (readData == 8'h11);
        last_mod   = (mod_reg == IW'(QSFP_COUNT - 1));
        is_capture = (state_reg == ST_CAPTURE);
        module_end = is_capture && (((idx_reg == 4'd0) && !id_valid) || (idx_reg == 4'd12));
        lo_capture = is_capture && (idx_reg != 4'd0) && !idx_reg[0];
        word_sel   = 3'((idx_reg - 4'd1) >> 1);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state_reg;
        scanBusy   = (state_reg != ST_IDLE);
        scanDone   = (state_reg == ST_DONE);
        case (state_reg)
            ST_IDLE:    if (interval_reg == '0) state_next = ST_ISSUE;
            ST_ISSUE:   state_next = (READ_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
            ST_WAIT:    if (wait_reg == '0) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = (module_end && last_mod) ? ST_DONE : ST_ISSUE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Sequencer: interval timer, latency timer, module/byte walk, address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interval_reg    <= '0;
            wait_reg        <= '0;
            mod_reg         <= '0;
            idx_reg         <= '0;
            hi_reg          <= '0;
            readAddress_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (interval_reg != '0) begin
                        interval_reg <= interval_reg - 1'b1;
                    end else begin
                        mod_reg <= '0;
                        idx_reg <= '0;
                    end
                end
                ST_ISSUE: begin
                    readAddress_reg <= AW'({mod_reg, byte_offset(idx_reg)});
                    wait_reg        <= WW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
                end
                ST_WAIT: begin
                    if (wait_reg != '0) wait_reg <= wait_reg - 1'b1;
                end
                ST_CAPTURE: begin
                    if (idx_reg[0]) hi_reg <= readData;
                    if (module_end) begin
                        mod_reg <= last_mod ? '0 : mod_reg + 1'b1;
                        idx_reg <= '0;
                    end else begin
                        idx_reg <= idx_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    interval_reg <= CW'(SCAN_INTERVAL - 1);
                end
                default: ;
            endcase
        end
    end

    // Staging array: presence from the identifier, words on each low-byte capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_present_reg <= '0;
            for (int m = 0; m < QSFP_COUNT; m++) begin
                for (int w = 0; w < 6; w++) stage_word_reg[m][w] <= '0;
            end
        end else if (is_capture) begin
            if (idx_reg == 4'd0) begin
                stage_present_reg[mod_reg] <= id_valid;
                if (!id_valid) begin
                    for (int w = 0; w < 6; w++) stage_word_reg[mod_reg][w] <= '0;
                end
            end else if (lo_capture) begin
                stage_word_reg[mod_reg][word_sel] <= {hi_reg, readData};
            end
        end
    end

    // Per-module word snapshot, copied only in DONE
    for (genvar gi = 0; gi < QSFP_COUNT; gi++) begin : g_pub
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int w = 0; w < 6; w++) pub_word_reg[gi][w] <= '0;
            end else if (state_reg == ST_DONE) begin
                for (int w = 0; w < 6; w++) pub_word_reg[gi][w] <= stage_word_reg[gi][w];
            end
        end
    end

    // Presence bitmap and scan counter, also updated only in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pub_present_reg <= '0;
            scanCount_reg   <= '0;
        end else if (state_reg == ST_DONE) begin
            pub_present_reg <= stage_present_reg;
            scanCount_reg   <= scanCount_reg + 16'd1;
        end
    end

`ifdef QSFP_DIAG_ALARM_EN
    logic [QSFP_COUNT-1:0] stage_alarm_reg;
    logic [QSFP_COUNT-1:0] pub_alarm_reg;

    // Over-temperature flag staged when the temperature low byte lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_alarm_reg <= '0;
        end else if (is_capture) begin
            if ((idx_reg == 4'd0) && !id_valid) begin
                stage_alarm_reg[mod_reg] <= 1'b0;
            end else if (idx_reg == 4'd2) begin
                stage_alarm_reg[mod_reg] <= ($signed({hi_reg, readData}) > TEMP_ALARM_THRESHOLD);
            end
        end
    end

    // Alarm bitmap published with the rest of the snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pub_alarm_reg <= '0;
        end else if (state_reg == ST_DONE) begin
            pub_alarm_reg <= stage_alarm_reg;
        end
    end

    assign tempAlarm = pub_alarm_reg;
`else
    logic unused_threshold;
    assign unused_threshold = ^TEMP_ALARM_THRESHOLD;
    assign tempAlarm        = '0;
`endif

    if (MW > 0) begin : g_diag_mod
        assign diag_mod = diagAddress[MW+2:3];
    end else begin : g_diag_mod_single
        assign diag_mod = '0;
    end
    assign diag_word = diagAddress[2:0];

    // Registered CSR read of the published snapshot; words 6..7 read 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diagData_reg <= '0;
        end else if ((int'(diag_mod) < QSFP_COUNT) && (diag_word < 3'd6)) begin
            diagData_reg <= pub_word_reg[diag_mod][diag_word];
        end else begin
            diagData_reg <= '0;
        end
    end

    assign readAddress = readAddress_reg;
    assign diagData    = diagData_reg;
    assign present     = pub_present_reg;
    assign scanCount   = scanCount_reg;

endmodule
